// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: pops IR/DR words from the command FIFOs, drives the TAP
// pins, and packs captured DR bits into bytes for the TDO FIFO.
module jtag_shift_engine #(
  parameter int DATA_INSTRUCTION = 10,
  parameter int DATA_FIFO        = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int CLK_DIV          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op,
  input  logic                          work,
  output logic                          busy,
  input  logic [DATA_INSTRUCTION-1:0]   rdata_instruction,
  output logic                          rd_instruction,
  input  logic                          empty_instruction,
  input  logic [DATA_FIFO-1:0]          rdata_data,
  output logic                          rd_data,
  input  logic                          empty_data,
  input  logic                          full_data,
  input  logic [$clog2(FIFO_DEPTH)-1:0] usedw_data,
  output logic [DATA_FIFO-1:0]          wdata_tdo,
  output logic                          wr_tdo,
  input  logic                          full_tdo,
  output logic                          ovf,
  output logic                          tck,
  output logic                          tms,
  output logic                          tdi,
  input  logic                          tdo
);
  localparam int DR_MAX   = DATA_FIFO * FIFO_DEPTH;
  localparam int MAX_BITS = (DATA_INSTRUCTION > DR_MAX) ? DATA_INSTRUCTION : DR_MAX;
  localparam int CW       = $clog2(MAX_BITS + 1);
  localparam int SW       = (DATA_INSTRUCTION > DATA_FIFO) ? DATA_INSTRUCTION : DATA_FIFO;
  localparam int WW       = $clog2(SW);
  localparam int BW       = $clog2(DATA_FIFO);
  localparam int DW       = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    ST_TAP_RESET, ST_IDLE, ST_NAV_IN, ST_SHIFT, ST_NAV_OUT
  } state_t;

  state_t                state_reg, state_next;
  logic [DW-1:0]         div_reg, div_next;
  logic                  tck_reg, tck_next, tms_reg, tms_next, tdi_reg, tdi_next;
  logic                  busy_reg, busy_next, op_reg, op_next;
  logic [2:0]            step_reg, step_next;
  logic [CW-1:0]         total_reg, total_next, bit_reg, bit_next;
  logic [WW-1:0]         wbit_reg, wbit_next;
  logic [SW-1:0]         sreg_reg, sreg_next;
  logic [DATA_FIFO-1:0]  cap_reg, cap_next, wdata_reg, wdata_next;
  logic [BW-1:0]         cap_cnt_reg, cap_cnt_next;
  logic                  rd_i_reg, rd_i_next, rd_d_reg, rd_d_next;
  logic                  wr_reg, wr_next, ovf_reg, ovf_next;
  logic                  tick, rise, fall, load;
  logic [SW-1:0]         load_word;
  logic [CW-1:0]         n_words;
  logic [WW-1:0]         wlast;

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    tck_next     = tck_reg;
    tms_next     = tms_reg;
    tdi_next     = tdi_reg;
    busy_next    = busy_reg;
    op_next      = op_reg;
    step_next    = step_reg;
    total_next   = total_reg;
    bit_next     = bit_reg;
    wbit_next    = wbit_reg;
    sreg_next    = sreg_reg;
    cap_next     = cap_reg;
    cap_cnt_next = cap_cnt_reg;
    wdata_next   = wdata_reg;
    ovf_next     = ovf_reg;
    rd_i_next    = 1'b0;
    rd_d_next    = 1'b0;
    wr_next      = 1'b0;
    load         = 1'b0;
    load_word    = '0;
    rise         = 1'b0;
    fall         = 1'b0;
    tick         = (div_reg == DW'(CLK_DIV - 1));
    n_words      = full_data ? CW'(FIFO_DEPTH) : CW'(usedw_data);
    wlast        = op_reg ? WW'(DATA_FIFO - 1) : WW'(DATA_INSTRUCTION - 1);

    if (state_reg != ST_IDLE) begin
      div_next = tick ? '0 : div_reg + 1'b1;
      if (tick) tck_next = ~tck_reg;
      rise = tick & ~tck_reg;
      fall = tick & tck_reg;
    end

    case (state_reg)
      ST_TAP_RESET: begin
        if (fall) begin
          if (step_reg == 3'd5) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            tms_next   = 1'b0;
          end else begin
            step_next = step_reg + 1'b1;
            tms_next  = (step_reg < 3'd4);
          end
        end
      end
      ST_IDLE: begin
        div_next = '0;
        tck_next = 1'b0;
        tms_next = 1'b0;
        if (work && (op ? !empty_data : !empty_instruction)) begin
          state_next   = ST_NAV_IN;
          busy_next    = 1'b1;
          op_next      = op;
          step_next    = '0;
          tms_next     = 1'b1;
          cap_cnt_next = '0;
          total_next   = op ? n_words * CW'(DATA_FIFO) : CW'(DATA_INSTRUCTION);
        end
      end
      ST_NAV_IN: begin
        if (fall) begin
          if (step_reg == (op_reg ? 3'd2 : 3'd3)) begin
            state_next = ST_SHIFT;
            bit_next   = '0;
            tms_next   = (total_reg == CW'(1));
            load       = 1'b1;
          end else begin
            step_next = step_reg + 1'b1;
            tms_next  = !op_reg && (step_reg == 3'd0);
          end
        end
      end
      ST_SHIFT: begin
        // Capture register fills from the MSB so the first TDO bit ends at bit 0.
        if (rise && op_reg) begin
          cap_next = {tdo, cap_reg[DATA_FIFO-1:1]};
          if (cap_cnt_reg == BW'(DATA_FIFO - 1)) begin
            cap_cnt_next = '0;
            if (full_tdo) begin
              ovf_next = 1'b1;
            end else begin
              wr_next    = 1'b1;
              wdata_next = {tdo, cap_reg[DATA_FIFO-1:1]};
            end
          end else begin
            cap_cnt_next = cap_cnt_reg + 1'b1;
          end
        end
        if (fall) begin
          if (bit_reg == total_reg - 1'b1) begin
            state_next = ST_NAV_OUT;
            step_next  = '0;
            tms_next   = 1'b1;
          end else begin
            bit_next = bit_reg + 1'b1;
            tms_next = (bit_reg + CW'(2) == total_reg);
            if (wbit_reg == wlast) begin
              load = 1'b1;
            end else begin
              wbit_next = wbit_reg + 1'b1;
              tdi_next  = sreg_reg[0];
              sreg_next = sreg_reg >> 1;
            end
          end
        end
      end
      ST_NAV_OUT: begin
        // Step 2 waits out the half-period after the final falling edge.
        if (step_reg == 3'd2) begin
          if (tick) begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
            tck_next   = 1'b0;
            tms_next   = 1'b0;
            div_next   = '0;
          end
        end else if (fall) begin
          step_next = step_reg + 1'b1;
          tms_next  = 1'b0;
        end
      end
      default: state_next = ST_TAP_RESET;
    endcase

    if (load) begin
      load_word = op_reg ? SW'(rdata_data) : SW'(rdata_instruction);
      tdi_next  = load_word[0];
      sreg_next = load_word >> 1;
      wbit_next = '0;
      rd_d_next = op_reg;
      rd_i_next = ~op_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_TAP_RESET;
      div_reg     <= '0;
      tck_reg     <= 1'b0;
      tms_reg     <= 1'b1;
      tdi_reg     <= 1'b0;
      busy_reg    <= 1'b1;
      op_reg      <= 1'b0;
      step_reg    <= '0;
      total_reg   <= '0;
      bit_reg     <= '0;
      wbit_reg    <= '0;
      sreg_reg    <= '0;
      cap_reg     <= '0;
      cap_cnt_reg <= '0;
      wdata_reg   <= '0;
      ovf_reg     <= 1'b0;
      rd_i_reg    <= 1'b0;
      rd_d_reg    <= 1'b0;
      wr_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      tck_reg     <= tck_next;
      tms_reg     <= tms_next;
      tdi_reg     <= tdi_next;
      busy_reg    <= busy_next;
      op_reg      <= op_next;
      step_reg    <= step_next;
      total_reg   <= total_next;
      bit_reg     <= bit_next;
      wbit_reg    <= wbit_next;
      sreg_reg    <= sreg_next;
      cap_reg     <= cap_next;
      cap_cnt_reg <= cap_cnt_next;
      wdata_reg   <= wdata_next;
      ovf_reg     <= ovf_next;
      rd_i_reg    <= rd_i_next;
      rd_d_reg    <= rd_d_next;
      wr_reg      <= wr_next;
    end
  end

  assign busy           = busy_reg;
  assign tck            = tck_reg;
  assign tms            = tms_reg;
  assign tdi            = tdi_reg;
  assign rd_instruction = rd_i_reg;
  assign rd_data        = rd_d_reg;
  assign wr_tdo         = wr_reg;
  assign wdata_tdo      = wdata_reg;
  assign ovf            = ovf_reg;
endmodule

// File: tb/tb_jtag_shift_engine.sv
// Scoreboard bench for jtag_shift_engine: expected TAP edges and TDO bytes are
// queued when a scan is issued and consumed by an independent pin monitor.
module tb_jtag_shift_engine;
  localparam int DI = 10, DF = 8, DEPTH = 16, CDIV = 2;

  logic clk = 1'b0, rst = 1'b1, op = 1'b0, work = 1'b0;
  logic busy, rd_instruction, rd_data, wr_tdo, ovf, tck, tms, tdi, tdo, full_tdo;
  logic [DI-1:0] rdata_instruction = '0;
  logic [DF-1:0] rdata_data = '0, wdata_tdo;
  logic          empty_instruction = 1'b1, empty_data = 1'b1, full_data = 1'b0;
  logic [3:0]    usedw_data = '0;

  typedef struct {bit tms; bit tdi; bit chk; bit dr;} ev_t;
  ev_t          ev_q[$];
  logic [7:0]   byte_q[$];
  bit           tdo_q[$];
  logic [DI-1:0] iq[$];
  logic [DF-1:0] dq[$];
  logic [15:0]  wq[$];

  int checks = 0, errors = 0;
  int rd_i_cnt = 0, rd_d_cnt = 0, wr_cnt = 0, dr_edges = 0, exp_wr = 0;
  bit loop_mode = 1'b0, exp_ovf = 1'b0, tdo_cur = 1'b0, prev_tck = 1'b0;
  logic [15:0] blk_mask = '0;

  jtag_shift_engine #(.DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .FIFO_DEPTH(DEPTH), .CLK_DIV(CDIV)) dut (
    .clk(clk), .rst(rst), .op(op), .work(work), .busy(busy),
    .rdata_instruction(rdata_instruction), .rd_instruction(rd_instruction),
    .empty_instruction(empty_instruction), .rdata_data(rdata_data), .rd_data(rd_data),
    .empty_data(empty_data), .full_data(full_data), .usedw_data(usedw_data),
    .wdata_tdo(wdata_tdo), .wr_tdo(wr_tdo), .full_tdo(full_tdo), .ovf(ovf),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  assign tdo      = loop_mode ? tdi : tdo_cur;
  assign full_tdo = (dr_edges < 128) ? blk_mask[dr_edges / 8] : 1'b0;

  // Show-ahead FIFO models
  always @(posedge clk) begin
    if (rd_data === 1'b1 && dq.size() != 0) void'(dq.pop_front());
    if (rd_instruction === 1'b1 && iq.size() != 0) void'(iq.pop_front());
    empty_data        <= (dq.size() == 0);
    full_data         <= (dq.size() >= DEPTH);
    usedw_data        <= 4'(dq.size());
    rdata_data        <= (dq.size() != 0) ? dq[0] : '0;
    empty_instruction <= (iq.size() == 0);
    rdata_instruction <= (iq.size() != 0) ? iq[0] : '0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one line per TDO byte, compare pins at each TCK rise.
  always @(negedge clk) begin
    ev_t e;
    if (tck === 1'b1 && prev_tck === 1'b0) begin
      if (ev_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_tck_rise: tms=%0b tdi=%0b", tms, tdi);
      end else begin
        e = ev_q.pop_front();
        chk("tms_at_rise", tms, e.tms);
        if (e.chk) chk("tdi_at_rise", tdi, e.tdi);
        if (e.dr) dr_edges++;
      end
      if (tdo_q.size() != 0) void'(tdo_q.pop_front());
    end
    prev_tck = tck;
    tdo_cur  = (tdo_q.size() != 0) ? tdo_q[0] : 1'b0;
    if (rd_data === 1'b1) rd_d_cnt++;
    if (rd_instruction === 1'b1) rd_i_cnt++;
    if (wr_tdo === 1'b1) begin
      wr_cnt++;
      if (byte_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wr_tdo: wdata_tdo=%0h", wdata_tdo);
      end else begin
        $display("tdo byte %0h (expected %0h)", wdata_tdo, byte_q[0]);
        chk("wdata_tdo", wdata_tdo, byte_q.pop_front());
      end
    end
  end

  task automatic push_ev(input bit ms, input bit di, input bit c, input bit d, input bit t);
    ev_t e;
    e.tms = ms; e.tdi = di; e.chk = c; e.dr = d;
    ev_q.push_back(e);
    tdo_q.push_back(t);
  endtask

  // Reference model: TAP walk and byte packing derived from the scan contents.
  task automatic plan_scan(input bit sop);
    int w, nb;
    logic [15:0] wd;
    logic [7:0] acc;
    bit b, t;
    w = sop ? DF : DI;
    nb = w * wq.size();
    acc = '0;
    push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
    if (!sop) push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
    push_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    push_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    for (int i = 0; i < nb; i++) begin
      wd = wq[i / w];
      b  = wd[i % w];
      t  = loop_mode ? b : 1'($urandom);
      push_ev(i == nb - 1, b, 1'b1, sop, t);
      if (sop) begin
        acc[i % 8] = t;
        if (i % 8 == 7) begin
          if (blk_mask[i / 8]) exp_ovf = 1'b1;
          else begin byte_q.push_back(acc); exp_wr++; end
        end
      end
    end
    push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
    push_ev(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic start_scan(input bit sop, input int nw, input bit fixed, input logic [9:0] fval);
    logic [31:0] v;
    wq.delete();
    exp_wr = 0;
    for (int i = 0; i < nw; i++) begin
      v = fixed ? 32'(fval) : $urandom;
      if (sop) begin wq.push_back(16'(v[7:0])); dq.push_back(v[7:0]); end
      else     begin wq.push_back(16'(v[9:0])); iq.push_back(v[9:0]); end
    end
    dr_edges = 0;
    plan_scan(sop);
    repeat (2) @(negedge clk);
    op = sop; work = 1'b1;
    @(negedge clk);
    work = 1'b0;
    chk("busy_after_work", busy, 1);
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (busy !== 1'b0 && cyc < 6000) begin @(negedge clk); cyc++; end
    chk(name, busy, 0);
  endtask

  task automatic run_scan(input bit sop, input int nw, input bit extra, input bit fixed, input logic [9:0] fval);
    int rdi0, rdd0, wr0;
    rdi0 = rd_i_cnt; rdd0 = rd_d_cnt; wr0 = wr_cnt;
    start_scan(sop, nw, fixed, fval);
    if (extra) begin
      repeat (10) @(negedge clk);
      op = ~sop; work = 1'b1;
      @(negedge clk);
      work = 1'b0;
    end
    wait_idle("scan_finished");
    $display("scan op=%0b words=%0d wr=%0d ovf=%0b", sop, nw, wr_cnt - wr0, ovf);
    chk("events_left", ev_q.size(), 0);
    chk("rd_instruction_pulses", rd_i_cnt - rdi0, sop ? 0 : 1);
    chk("rd_data_pulses", rd_d_cnt - rdd0, sop ? nw : 0);
    chk("wr_tdo_pulses", wr_cnt - wr0, exp_wr);
    chk("bytes_left", byte_q.size(), 0);
    chk("ovf", ovf, exp_ovf);
    @(negedge clk);
    chk("idle_tck", tck, 0);
    chk("idle_tms", tms, 0);
  endtask

  task automatic ignored(input bit sop);
    int rdi0, rdd0, tck_seen, busy_seen;
    rdi0 = rd_i_cnt; rdd0 = rd_d_cnt; tck_seen = 0; busy_seen = 0;
    op = sop; work = 1'b1;
    @(negedge clk);
    work = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tck === 1'b1) tck_seen++;
      if (busy !== 1'b0) busy_seen++;
      @(negedge clk);
    end
    $display("ignored work op=%0b tck_high=%0d busy=%0d", sop, tck_seen, busy_seen);
    chk("ignored_tck", tck_seen, 0);
    chk("ignored_busy", busy_seen, 0);
    chk("ignored_pops", (rd_i_cnt - rdi0) + (rd_d_cnt - rdd0), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tck"}, tck, 0);
    chk({tag, "_tms"}, tms, 1);
    chk({tag, "_tdi"}, tdi, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rd_instruction"}, rd_instruction, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_wr_tdo"}, wr_tdo, 0);
    chk({tag, "_wdata_tdo"}, wdata_tdo, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic push_tap_reset();
    for (int i = 0; i < 6; i++) push_ev(i < 5, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int rd0, wr0, cyc;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    push_tap_reset();
    rst = 1'b0;
    wait_idle("tap_reset_done");
    chk("tap_reset_rises", ev_q.size(), 0);

    run_scan(1'b0, 1, 1'b0, 1'b1, 10'b0000000110);
    loop_mode = 1'b1;
    run_scan(1'b1, 3, 1'b0, 1'b1, 10'h0C4);
    loop_mode = 1'b0;
    blk_mask = 16'h0002;
    run_scan(1'b1, 3, 1'b0, 1'b0, '0);
    blk_mask = '0;

    ignored(1'b1);
    ignored(1'b0);

    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) run_scan(1'b1, $urandom_range(1, 5), 1'($urandom), 1'b0, '0);
      else run_scan(1'b0, 1, 1'($urandom), 1'b0, '0);
    end
    run_scan(1'b1, DEPTH, 1'b1, 1'b0, '0);

    // Reset in the middle of a DR shift
    start_scan(1'b1, 4, 1'b0, '0);
    cyc = 0;
    while (dr_edges < 10 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("reached_mid_shift", dr_edges >= 10, 1);
    #1;
    rst = 1'b1;
    ev_q.delete(); byte_q.delete(); tdo_q.delete(); dq.delete();
    exp_ovf = 1'b0;
    rd0 = rd_d_cnt; wr0 = wr_cnt;
    @(negedge clk);
    check_reset_vals("midrst");
    push_tap_reset();
    rst = 1'b0;
    wait_idle("midrst_tap_reset_done");
    chk("midrst_tap_rises", ev_q.size(), 0);
    chk("midrst_no_rd_data", rd_d_cnt - rd0, 0);
    chk("midrst_no_wr_tdo", wr_cnt - wr0, 0);

    run_scan(1'b1, 2, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
